// File: rtl/mem_stage_pkg.sv
// ============================================================
// Module : mem_stage_pkg
// Write-back select encodings and link offset shared by EXE decode and MEM.
// Rev    : 1.0
// ============================================================
`default_nettype none

package mem_stage_pkg;

  localparam logic [1:0]  SEL_ALU     = 2'b00;
  localparam logic [1:0]  SEL_MEM     = 2'b01;
  localparam logic [1:0]  SEL_LINK    = 2'b10;
  localparam logic [31:0] LINK_OFFSET = 32'd4;

endpackage

`default_nettype wire

// File: rtl/mem_stage_if.sv
// ============================================================
// Module : mem_stage_if
// EXE/MEM inputs, MEM/WB outputs and the MEM->EXE forwarding path.
// Rev    : 1.0
// ============================================================
`default_nettype none

interface mem_stage_if;

  logic        hold;
  logic [31:0] MEM_pc;
  logic [31:0] MEM_b;
  logic [31:0] MEM_c;
  logic [4:0]  MEM_num_write;
  logic        MEM_mem_write;
  logic        MEM_reg_write;
  logic [1:0]  MEM_s_data_write;

  logic [31:0] WB_pc;
  logic [31:0] WB_data;
  logic [4:0]  WB_num_write;
  logic        WB_reg_write;
  logic        WB_misalign;

  logic        fwd_valid;
  logic [4:0]  fwd_num;
  logic [31:0] fwd_data;

  modport master (
    output hold, MEM_pc, MEM_b, MEM_c, MEM_num_write,
           MEM_mem_write, MEM_reg_write, MEM_s_data_write,
    input  WB_pc, WB_data, WB_num_write, WB_reg_write, WB_misalign,
           fwd_valid, fwd_num, fwd_data
  );

  modport slave (
    input  hold, MEM_pc, MEM_b, MEM_c, MEM_num_write,
           MEM_mem_write, MEM_reg_write, MEM_s_data_write,
    output WB_pc, WB_data, WB_num_write, WB_reg_write, WB_misalign,
           fwd_valid, fwd_num, fwd_data
  );

endinterface

`default_nettype wire

// File: rtl/mem_stage_data_ram.sv
// ============================================================
// Module : data_ram
// Word-wide data memory: asynchronous read, synchronous write, no reset.
// Rev    : 1.0
// ============================================================
`default_nettype none

module data_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic          clock,
  input  wire logic          we,
  input  wire logic [AW-1:0] addr,
  input  wire logic [31:0]   wdata,
  output logic      [31:0]   rdata
);

  logic [31:0] r_mem [DEPTH];

  // Read and write share one index; the read sees the pre-edge word.
  always_ff @(posedge clock) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  assign rdata = r_mem[addr];

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================
// Module : mem_stage
// MEM stage: data access, write-back select, forwarding and MEM/WB register.
// Rev    : 1.0
// ============================================================
`default_nettype none

module mem_stage #(
  parameter int DMEM_WORDS = 1024
) (
  input  wire logic  clock,
  input  wire logic  reset,
  mem_stage_if.slave bus
);

  import mem_stage_pkg::*;

  localparam int ADDR_W = $clog2(DMEM_WORDS);

  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_rdata;
  logic [31:0]       w_wb_data;
  logic              w_misalign;
  logic              w_we;
  logic              w_unused_addr;

  logic [31:0]       r_wb_pc;
  logic [31:0]       r_wb_data;
  logic [4:0]        r_wb_num_write;
  logic              r_wb_reg_write;
  logic              r_wb_misalign;

  assign w_idx = bus.MEM_c[ADDR_W+1:2];

  // Address bits above the RAM range are dropped so accesses wrap.
  generate
    if (ADDR_W + 2 < 32) begin : g_addr_hi
      assign w_unused_addr = &{1'b0, bus.MEM_c[31:ADDR_W+2]};
    end else begin : g_addr_full
      assign w_unused_addr = 1'b0;
    end
  endgenerate

  assign w_misalign = (bus.MEM_c[1:0] != 2'b00) &&
                      (bus.MEM_mem_write || (bus.MEM_s_data_write == SEL_MEM));

  assign w_we = bus.MEM_mem_write && !w_misalign && !bus.hold && reset;

  data_ram #(
    .DEPTH (DMEM_WORDS),
    .AW    (ADDR_W)
  ) u_data_ram (
    .clock (clock),
    .we    (w_we),
    .addr  (w_idx),
    .wdata (bus.MEM_b),
    .rdata (w_rdata)
  );

  always_comb begin
    w_wb_data = bus.MEM_c;
    case (bus.MEM_s_data_write)
      SEL_MEM:  w_wb_data = w_rdata;
      SEL_LINK: w_wb_data = bus.MEM_pc + LINK_OFFSET;
      default:  w_wb_data = bus.MEM_c;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wb_pc        <= 32'd0;
      r_wb_data      <= 32'd0;
      r_wb_num_write <= 5'd0;
      r_wb_reg_write <= 1'b0;
      r_wb_misalign  <= 1'b0;
    end else if (!bus.hold) begin
      r_wb_pc        <= bus.MEM_pc;
      r_wb_data      <= w_wb_data;
      r_wb_num_write <= bus.MEM_num_write;
      r_wb_reg_write <= bus.MEM_reg_write;
      r_wb_misalign  <= w_misalign;
    end
  end

  assign bus.WB_pc        = r_wb_pc;
  assign bus.WB_data      = r_wb_data;
  assign bus.WB_num_write = r_wb_num_write;
  assign bus.WB_reg_write = r_wb_reg_write;
  assign bus.WB_misalign  = r_wb_misalign;

  assign bus.fwd_valid = bus.MEM_reg_write && (bus.MEM_num_write != 5'd0);
  assign bus.fwd_num   = bus.MEM_num_write;
  assign bus.fwd_data  = w_wb_data;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================
// Module : tb_mem_stage
// Scoreboard bench for mem_stage against a word-array reference model.
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_mem_stage;

  localparam int WORDS = 1024;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic [4:0]  num;
    logic        rw;
    logic        mis;
    bit          dk;
  } exp_t;

  logic clock;
  logic reset;

  mem_stage_if bus ();

  mem_stage #(
    .DMEM_WORDS (WORDS)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem   [WORDS];
  bit          m_known [WORDS];
  exp_t        m_wb;
  exp_t        q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One instruction per cycle; the expected MEM/WB state after the next edge is queued.
  task automatic drive(input logic [31:0] pc, input logic [31:0] b, input logic [31:0] c,
                       input logic [4:0] num, input logic mw, input logic rw,
                       input logic [1:0] sel, input logic hld);
    int          idx;
    logic        mis;
    logic [31:0] wbv;
    bit          wk;
    @(negedge clock);
    reset                = 1'b1;
    bus.hold             = hld;
    bus.MEM_pc           = pc;
    bus.MEM_b            = b;
    bus.MEM_c            = c;
    bus.MEM_num_write    = num;
    bus.MEM_mem_write    = mw;
    bus.MEM_reg_write    = rw;
    bus.MEM_s_data_write = sel;
    idx = int'((c >> 2) % WORDS);
    mis = (c % 4 != 0) && (mw || sel == 2'd1);
    if (sel == 2'd1) begin
      wbv = m_mem[idx];
      wk  = m_known[idx];
    end else if (sel == 2'd2) begin
      wbv = pc + 32'd4;
      wk  = 1'b1;
    end else begin
      wbv = c;
      wk  = 1'b1;
    end
    #1;
    chk("fwd_valid", {31'd0, bus.fwd_valid}, {31'd0, rw && (num != 5'd0)});
    chk("fwd_num", {27'd0, bus.fwd_num}, {27'd0, num});
    if (wk) chk("fwd_data", bus.fwd_data, wbv);
    if (!hld) begin
      m_wb = '{pc: pc, data: wbv, num: num, rw: rw, mis: mis, dk: wk};
      if (mw && !mis) begin
        m_mem[idx]   = b;
        m_known[idx] = 1'b1;
      end
    end
    q.push_back(m_wb);
  endtask

  // Reset lands mid-cycle with a store already presented; the store must be lost.
  task automatic reset_mid_store(input logic [31:0] addr, input logic [31:0] val);
    @(negedge clock);
    bus.hold             = 1'b0;
    bus.MEM_pc           = 32'h0000_0200;
    bus.MEM_b            = val;
    bus.MEM_c            = addr;
    bus.MEM_num_write    = 5'd0;
    bus.MEM_mem_write    = 1'b1;
    bus.MEM_reg_write    = 1'b0;
    bus.MEM_s_data_write = 2'd0;
    #2 reset = 1'b0;
    #1;
    chk("rst_WB_pc", bus.WB_pc, 32'd0);
    chk("rst_WB_data", bus.WB_data, 32'd0);
    chk("rst_WB_num_write", {27'd0, bus.WB_num_write}, 32'd0);
    chk("rst_WB_reg_write", {31'd0, bus.WB_reg_write}, 32'd0);
    chk("rst_WB_misalign", {31'd0, bus.WB_misalign}, 32'd0);
    m_wb = '{pc: 32'd0, data: 32'd0, num: 5'd0, rw: 1'b0, mis: 1'b0, dk: 1'b1};
    q.push_back(m_wb);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("WB_pc", bus.WB_pc, e.pc);
        chk("WB_num_write", {27'd0, bus.WB_num_write}, {27'd0, e.num});
        chk("WB_reg_write", {31'd0, bus.WB_reg_write}, {31'd0, e.rw});
        chk("WB_misalign", {31'd0, bus.WB_misalign}, {31'd0, e.mis});
        if (e.dk) chk("WB_data", bus.WB_data, e.data);
      end
    end
  end

  initial begin : stimulus
    logic [31:0] c;
    int          guard;
    for (int i = 0; i < WORDS; i++) m_known[i] = 1'b0;
    reset                = 1'b0;
    bus.hold             = 1'b0;
    bus.MEM_pc           = 32'd0;
    bus.MEM_b            = 32'd0;
    bus.MEM_c            = 32'd0;
    bus.MEM_num_write    = 5'd0;
    bus.MEM_mem_write    = 1'b0;
    bus.MEM_reg_write    = 1'b0;
    bus.MEM_s_data_write = 2'd0;
    repeat (2) @(posedge clock);
    #1;
    chk("init_WB_pc", bus.WB_pc, 32'd0);
    chk("init_WB_data", bus.WB_data, 32'd0);
    chk("init_WB_reg_write", {31'd0, bus.WB_reg_write}, 32'd0);

    drive(32'h100, 32'h1111_1111, 32'h10, 5'd0, 1'b1, 1'b0, 2'd0, 1'b0);
    drive(32'h104, 32'h0, 32'hABCD, 5'd3, 1'b0, 1'b1, 2'd0, 1'b0);
    reset_mid_store(32'h10, 32'hDEAD_BEEF);
    drive(32'h108, 32'h0, 32'h10, 5'd7, 1'b0, 1'b1, 2'd1, 1'b0);

    drive(32'h10C, 32'h1234_5678, 32'h40, 5'd0, 1'b1, 1'b0, 2'd0, 1'b0);
    drive(32'h110, 32'h0, 32'h40, 5'd5, 1'b0, 1'b1, 2'd1, 1'b0);
    drive(32'h0040_0020, 32'h0, 32'h0, 5'd31, 1'b0, 1'b1, 2'd2, 1'b0);
    drive(32'h114, 32'h0, 32'h5555, 5'd9, 1'b0, 1'b1, 2'd3, 1'b0);

    drive(32'h118, 32'hCAFE_F00D, 32'h42, 5'd0, 1'b1, 1'b0, 2'd0, 1'b0);
    drive(32'h11C, 32'h0, 32'h41, 5'd4, 1'b0, 1'b1, 2'd1, 1'b0);

    drive(32'h120, 32'hAAAA_0000, 32'h80, 5'd0, 1'b1, 1'b0, 2'd0, 1'b0);
    repeat (3) drive(32'h124, 32'hBBBB_0000, 32'h80, 5'd6, 1'b1, 1'b1, 2'd1, 1'b1);
    drive(32'h124, 32'hBBBB_0000, 32'h80, 5'd6, 1'b1, 1'b1, 2'd1, 1'b0);
    drive(32'h128, 32'h0, 32'h80, 5'd8, 1'b0, 1'b1, 2'd1, 1'b0);

    drive(32'h12C, 32'h0, 32'h77, 5'd0, 1'b0, 1'b1, 2'd0, 1'b0);
    drive(32'h130, 32'h0F0F_0F0F, 32'h1000, 5'd0, 1'b1, 1'b0, 2'd0, 1'b0);
    drive(32'h134, 32'h0, 32'h0, 5'd10, 1'b0, 1'b1, 2'd1, 1'b0);

    for (int n = 0; n < 400; n++) begin
      c = ($urandom & 32'h0000_F000) | ($urandom_range(0, 31) << 2);
      if ($urandom_range(0, 7) == 0) c = c | $urandom_range(1, 3);
      if ($urandom_range(0, 5) == 0) c = $urandom;
      drive($urandom, $urandom, c, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 4) == 0));
    end

    guard = 0;
    while (q.size() != 0 && guard < 10) begin
      @(posedge clock);
      guard++;
    end
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0 entries left", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage pipeline: the consumer of the EXE/MEM pipeline register outputs. It performs the data-memory access for loads and stores and selects the write-back value. It also drives the MEM→EXE forwarding path and registers everything into the MEM/WB boundary for the write-back stage. It sits between the EXE/MEM register and the register file write port.

## Interface
Parameters:
- DMEM_WORDS, 1024, data memory depth in 32-bit words; power of two.
- ADDR_W, $clog2(DMEM_WORDS), word-index width; derived, not overridden.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; clears every WB_* register and the fault flag.
- hold  in  1  stall; freezes WB_* registers and blocks memory writes.
- MEM_pc  in  32  PC of the instruction in MEM.
- MEM_b  in  32  store data (rt value).
- MEM_c  in  32  ALU result; byte address for loads/stores.
- MEM_num_write  in  5  destination register number.
- MEM_mem_write  in  1  store enable.
- MEM_reg_write  in  1  register write enable.
- MEM_s_data_write  in  2  write-back source select.
- WB_pc  out  32  registered MEM_pc.
- WB_data  out  32  registered write-back value.
- WB_num_write  out  5  registered destination.
- WB_reg_write  out  1  registered write enable.
- WB_misalign  out  1  registered alignment fault for the instruction now in WB.
- fwd_valid  out  1  combinational: MEM_reg_write && MEM_num_write != 0.
- fwd_num  out  5  combinational: MEM_num_write.
- fwd_data  out  32  combinational: write-back value selected this cycle.

## Operation
- Word index = MEM_c[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo DMEM_WORDS*4.
- misalign = (MEM_c[1:0] != 0) && (MEM_mem_write || MEM_s_data_write == 2'b01).
- Memory read is combinational from the word index.
- Memory write of MEM_b happens at posedge only when all of these hold: MEM_mem_write=1, misalign=0, hold=0, reset=1.
- Write-back select:
  - 2'b00: MEM_c.
  - 2'b01: read data.
  - 2'b10: MEM_pc + 4 (link), 32-bit wrap.
  - 2'b11: reserved; behaves as 2'b00.
- A misaligned load still returns the word at the truncated index. The fault flag records the error; nothing is suppressed.
- Memory contents are not cleared by reset and are undefined at power-up until written.

## Timing
- Reset (reset=0, any time, asynchronous):
  - WB_pc, WB_data, WB_misalign = 0; WB_num_write = 0; WB_reg_write = 0.
  - Outputs hold these values until the first posedge with reset=1.
  - A store present while reset is low is dropped.
- Normal operation (hold=0): MEM inputs appear on WB_* one posedge later. Latency is 1 cycle.
- hold=1: WB_* keep their values and no memory write occurs. Forwarding outputs still track the inputs.
- Read-during-write, same cycle and same index: read data is the old word. A load in the following cycle sees the new word (store-then-load back-to-back).
- fwd_* are purely combinational from the MEM inputs and RAM. They have no reset dependency beyond the inputs.

## Structure
- Shared package: the write-back select encodings (SEL_ALU=2'b00, SEL_MEM=2'b01, SEL_LINK=2'b10) and the link offset constant 32'd4. The EXE-side decoder uses the same constants.
- Sub-module `data_ram`:
  - DMEM_WORDS x 32 array.
  - Asynchronous read port; synchronous write port with write enable.
  - No reset.
- The top level holds the fault logic, the select mux, the forwarding outputs and the MEM/WB registers.

## Test plan
- Reset mid-stream: drive reset=0 asynchronously between edges while WB_* are non-zero → all WB_* read 0 immediately. A pending store to 0x10 of 0xDEADBEEF is not written; a later load from 0x10 returns the prior contents.
- Store then load: store 0x12345678 to 0x40, next cycle load from 0x40 with SEL_MEM to r5 → WB_data=0x12345678, WB_num_write=5, WB_reg_write=1 one cycle after the load.
- Link and ALU select:
  - MEM_pc=0x00400020 with SEL_LINK → WB_data=0x00400024.
  - SEL_ALU with MEM_c=0xABCD → WB_data=0xABCD.
  - Select 2'b11 → MEM_c.
- Misalignment: store to 0x42 → no write, and WB_misalign=1 next cycle. A load from 0x41 → WB_misalign=1, WB_data = word at index 0x10.
- Hold: hold=1 for 3 cycles with a store to 0x80 pending → WB_* unchanged and memory unchanged. On release, a single write occurs and WB_* update once.
- Forwarding and wrap:
  - MEM_reg_write=1 with num=0 → fwd_valid=0.
  - With DMEM_WORDS=1024, a store to 0x1000 then a load from 0x0 → the stored value is returned.
